// File: rtl/sort8_pkg.sv
// sort8_pkg: shared FSM state type, sizes and the 19-step Batcher odd-even merge schedule for sort8_sequencer
package sort8_pkg;
  typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;
  localparam int N_ELEM = 8;
  localparam int N_STEPS = 19;
  localparam logic [2:0] STEP_I [0:N_STEPS-1] = '{3'd0, 3'd2, 3'd4, 3'd6, 3'd0, 3'd1, 3'd4, 3'd5, 3'd1, 3'd5,
                                                  3'd0, 3'd1, 3'd2, 3'd3, 3'd2, 3'd3, 3'd1, 3'd3, 3'd5};
  localparam logic [2:0] STEP_J [0:N_STEPS-1] = '{3'd1, 3'd3, 3'd5, 3'd7, 3'd2, 3'd3, 3'd6, 3'd7, 3'd2, 3'd6,
                                                  3'd4, 3'd5, 3'd6, 3'd7, 3'd4, 3'd5, 3'd2, 3'd4, 3'd6};
endpackage

// File: rtl/sort8_sequencer_cmp_exchange.sv
// cmp_exchange: combinational compare-exchange; a/b in, desc selects order, lo_out takes min (asc) or max (desc), equal values pass straight through
module cmp_exchange #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         desc,
  output logic [W-1:0] lo_out,
  output logic [W-1:0] hi_out
);
  logic swap;
  assign swap = desc ? (a < b) : (a > b);
  assign lo_out = swap ? b : a;
  assign hi_out = swap ? a : b;
endmodule

// File: rtl/sort8_sequencer.sv
// sort8_sequencer: sorts eight W-bit values with one shared compare-exchange; in_valid/in_ready/in_data/in_desc in, out_valid/out_ready/out_data out, busy in SORT or DONE
module sort8_sequencer
  import sort8_pkg::*;
#(
  parameter int W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N_ELEM*W-1:0]   in_data,
  input  logic                  in_desc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N_ELEM*W-1:0]   out_data,
  output logic                  busy
);
  state_t state, state_nx;
  logic [4:0] step;
  logic [W-1:0] r [N_ELEM];
  logic desc_q;
  logic [2:0] i_idx, j_idx;
  logic [W-1:0] lo, hi;
  assign i_idx = STEP_I[step];
  assign j_idx = STEP_J[step];
  cmp_exchange #(.W(W)) u_cmp (
    .a(r[i_idx]),
    .b(r[j_idx]),
    .desc(desc_q),
    .lo_out(lo),
    .hi_out(hi)
  );
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (in_valid ? SORT : IDLE) :
               state == SORT ? (step == 5'(N_STEPS - 1) ? DONE : SORT) :
               (out_ready ? IDLE : DONE);
  end
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign busy = state != IDLE;
  for (genvar k = 0; k < N_ELEM; k++) begin : g_out
    assign out_data[W*k +: W] = r[k];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      step <= '0;
      desc_q <= 1'b0;
      for (int k = 0; k < N_ELEM; k++) r[k] <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && in_valid) begin
        for (int k = 0; k < N_ELEM; k++) r[k] <= in_data[W*k +: W];
        desc_q <= in_desc;
        step <= '0;
      end else if (state == SORT) begin
        r[i_idx] <= lo;
        r[j_idx] <= hi;
        if (step != 5'(N_STEPS - 1)) step <= step + 5'd1;
      end
    end
  end
endmodule
